// File: rtl/l_class_oc_echodriver.sv
// Echo driver: issues a numbered sequence of say requests into an echo
// server, checks the returned echo indications in order, and limits the
// number of requests in flight with a small credit counter.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for start; counters cleared by reset
// S_RUN   | issuing requests and accepting echoes
// S_DRAIN | all requests issued; waiting for the remaining echoes
// S_DONE  | run complete; counters hold until the next start
module l_class_oc_echodriver #(
    parameter int unsigned COUNT   = 16,
    parameter logic [31:0] BASE    = 32'h100,
    parameter int unsigned MAX_OUT = 4
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        start__ENA,
    output logic        start__RDY,
    output logic        say__ENA,
    output logic [31:0] say_v,
    input  logic        say__RDY,
    input  logic        echo__ENA,
    input  logic [31:0] echo_v,
    output logic        echo__RDY,
    output logic        done,
    output logic [15:0] errors,
    output logic [15:0] sent,
    output logic [15:0] received
);

    localparam logic [15:0] COUNT_W   = 16'(COUNT);
    localparam logic [15:0] LAST_W    = 16'(COUNT - 1);
    localparam logic [3:0]  MAX_OUT_W = 4'(MAX_OUT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] sent_q, sent_d;
    logic [15:0] received_q, received_d;
    logic [15:0] errors_q, errors_d;
    logic [3:0]  outstanding_q, outstanding_d;

    logic echo_take;
    logic echo_spurious;
    logic echo_good;
    logic echo_bad;

    // State and counter registers; reset aborts a run immediately.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q       <= S_IDLE;
            sent_q        <= '0;
            received_q    <= '0;
            errors_q      <= '0;
            outstanding_q <= '0;
        end else begin
            state_q       <= state_d;
            sent_q        <= sent_d;
            received_q    <= received_d;
            errors_q      <= errors_d;
            outstanding_q <= outstanding_d;
        end
    end

    // Handshake outputs, echo checking and next-state/counter updates.
    always_comb begin
        state_d       = state_q;
        sent_d        = sent_q;
        received_d    = received_q;
        errors_d      = errors_q;
        outstanding_d = outstanding_q;

        // echo__RDY decodes the state register only, never echo__ENA.
        start__RDY = (state_q == S_IDLE) || (state_q == S_DONE);
        echo__RDY  = (state_q == S_RUN) || (state_q == S_DRAIN);
        done       = (state_q == S_DONE);

        say__ENA = (state_q == S_RUN) && say__RDY &&
                   (sent_q < COUNT_W) && (outstanding_q < MAX_OUT_W);
        say_v    = say__ENA ? (BASE + {16'h0000, sent_q}) : 32'h0000_0000;

        // An echo with nothing outstanding is counted as an error but never
        // consumes a credit, so outstanding cannot underflow.
        echo_take     = echo__ENA && echo__RDY;
        echo_spurious = echo_take && (outstanding_q == 4'd0);
        echo_good     = echo_take && !echo_spurious;
        echo_bad      = echo_spurious ||
                        (echo_good && (echo_v != (BASE + {16'h0000, received_q})));

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start__ENA) begin
                    sent_d        = '0;
                    received_d    = '0;
                    errors_d      = '0;
                    outstanding_d = '0;
                    state_d       = S_RUN;
                end
            end
            S_RUN, S_DRAIN: begin
                if (say__ENA) begin
                    sent_d = sent_q + 16'd1;
                end
                if (echo_good) begin
                    received_d = received_q + 16'd1;
                end
                if (say__ENA && !echo_good) begin
                    outstanding_d = outstanding_q + 4'd1;
                end else if (!say__ENA && echo_good) begin
                    outstanding_d = outstanding_q - 4'd1;
                end
                if (echo_bad && (errors_q != 16'hFFFF)) begin
                    errors_d = errors_q + 16'd1;
                end
                if ((state_q == S_RUN) && say__ENA && (sent_q == LAST_W)) begin
                    state_d = S_DRAIN;
                end
                if ((state_q == S_DRAIN) && echo_good && (received_q == LAST_W)) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign errors   = errors_q;
    assign sent     = sent_q;
    assign received = received_q;

endmodule

// File: tb/tb_l_class_oc_echodriver.sv
// Self-checking bench for the echo driver. A queue-based echo server and an
// in-order sequence model predict every handshake, payload and counter value.
module tb_l_class_oc_echodriver;

    localparam int          COUNT   = 16;
    localparam logic [31:0] BASE    = 32'h100;
    localparam int          MAX_OUT = 4;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        start__ENA;
    logic        start__RDY;
    logic        say__ENA;
    logic [31:0] say_v;
    logic        say__RDY;
    logic        echo__ENA;
    logic [31:0] echo_v;
    logic        echo__RDY;
    logic        done;
    logic [15:0] errors;
    logic [15:0] sent;
    logic [15:0] received;

    int checks = 0;
    int errs   = 0;

    // reference model state
    int          exp_sent;
    int          exp_recv;
    int          exp_err;
    bit          active;
    logic [31:0] q[$];
    bit          corrupt_en;
    int          echo_budget;
    int          say_pulses;
    bit          check_steady;

    l_class_oc_echodriver #(.COUNT(COUNT), .BASE(BASE), .MAX_OUT(MAX_OUT)) dut (
        .CLK(CLK), .nRST(nRST),
        .start__ENA(start__ENA), .start__RDY(start__RDY),
        .say__ENA(say__ENA), .say_v(say_v), .say__RDY(say__RDY),
        .echo__ENA(echo__ENA), .echo_v(echo_v), .echo__RDY(echo__RDY),
        .done(done), .errors(errors), .sent(sent), .received(received)
    );

    always #5 CLK = ~CLK;

    task automatic reset_model();
        exp_sent   = 0;
        exp_recv   = 0;
        exp_err    = 0;
        say_pulses = 0;
        q.delete();
    endtask

    task automatic do_start();
        @(negedge CLK);
        say__RDY   = 1'b0;
        echo__ENA  = 1'b0;
        start__ENA = 1'b1;
        #1;
        checks++;
        if (start__RDY !== 1'b1) begin
            errs++;
            $display("FAIL start_rdy_before_start: got %b want 1", start__RDY);
        end
        reset_model();
        active = 1'b1;
    endtask

    // Randomised traffic against the server model; every cycle compares all
    // outputs with the values the sequence rules predict.
    task automatic run_traffic(input int say_pct, input int echo_pct, input int ncycles,
                               input bit stop_done, input int stop_sent, output bit saw_done);
        bit          exp_say, exp_erdy, exp_done, deliver;
        logic [31:0] ev, exp_v;
        saw_done = 1'b0;
        for (int i = 0; i < ncycles; i++) begin
            @(negedge CLK);
            start__ENA = 1'b0;
            say__RDY   = ($urandom_range(99) < say_pct);
            deliver    = (q.size() > 0) && ($urandom_range(99) < echo_pct) && (echo_budget != 0);
            ev = 32'h0;
            if (deliver) begin
                ev = q[0];
                if (corrupt_en && (exp_recv == 2 || exp_recv == 6)) ev[0] = ~ev[0];
            end
            echo__ENA = deliver;
            echo_v    = deliver ? ev : $urandom();
            #1;
            exp_erdy = active && (exp_recv < COUNT);
            exp_done = active && (exp_recv == COUNT);
            exp_say  = say__RDY && exp_erdy && (exp_sent < COUNT) && ((exp_sent - exp_recv) < MAX_OUT);
            exp_v    = exp_say ? BASE + 32'(exp_sent) : 32'h0;

            checks++;
            if (say__ENA !== exp_say) begin
                errs++;
                $display("FAIL say_ena t=%0t: got %b want %b", $time, say__ENA, exp_say);
            end
            checks++;
            if (say_v !== exp_v) begin
                errs++;
                $display("FAIL say_v t=%0t: got %h want %h", $time, say_v, exp_v);
            end
            checks++;
            if (echo__RDY !== exp_erdy) begin
                errs++;
                $display("FAIL echo_rdy t=%0t: got %b want %b", $time, echo__RDY, exp_erdy);
            end
            checks++;
            if (done !== exp_done) begin
                errs++;
                $display("FAIL done t=%0t: got %b want %b", $time, done, exp_done);
            end
            checks++;
            if (start__RDY !== !exp_erdy) begin
                errs++;
                $display("FAIL start_rdy t=%0t: got %b want %b", $time, start__RDY, !exp_erdy);
            end
            checks++;
            if (sent !== 16'(exp_sent)) begin
                errs++;
                $display("FAIL sent t=%0t: got %0d want %0d", $time, sent, exp_sent);
            end
            checks++;
            if (received !== 16'(exp_recv)) begin
                errs++;
                $display("FAIL received t=%0t: got %0d want %0d", $time, received, exp_recv);
            end
            checks++;
            if (errors !== 16'(exp_err)) begin
                errs++;
                $display("FAIL errors t=%0t: got %0d want %0d", $time, errors, exp_err);
            end
            if (check_steady && exp_sent >= 1 && exp_sent < COUNT) begin
                checks++;
                if ((sent - received) !== 16'd1) begin
                    errs++;
                    $display("FAIL steady_outstanding t=%0t: got %0d want 1", $time, sent - received);
                end
            end
            if (say__ENA === 1'b1) say_pulses++;

            if (exp_say) begin
                q.push_back(BASE + 32'(exp_sent));
                exp_sent++;
            end
            if (deliver && exp_erdy) begin
                void'(q.pop_front());
                if (ev != BASE + 32'(exp_recv)) exp_err++;
                exp_recv++;
                if (echo_budget > 0) echo_budget--;
            end
            if (stop_done && exp_done) begin
                saw_done = 1'b1;
                break;
            end
            if (stop_sent > 0 && exp_sent >= stop_sent) break;
        end
        @(negedge CLK);
        say__RDY  = 1'b0;
        echo__ENA = 1'b0;
        echo_v    = 32'h0;
    endtask

    task automatic check_final(input string name, input bit saw_done, input int want_err);
        #1;
        checks++;
        if (!saw_done) begin
            errs++;
            $display("FAIL %s_timeout: done not reached within budget", name);
        end
        checks++;
        if (done !== 1'b1) begin
            errs++;
            $display("FAIL %s_done: got %b want 1", name, done);
        end
        checks++;
        if (errors !== 16'(want_err)) begin
            errs++;
            $display("FAIL %s_errors: got %0d want %0d", name, errors, want_err);
        end
        checks++;
        if (sent !== 16'(COUNT) || received !== 16'(COUNT)) begin
            errs++;
            $display("FAIL %s_counts: got sent %0d received %0d want %0d", name, sent, received, COUNT);
        end
    endtask

    task automatic test_reset();
        nRST = 1'b0; start__ENA = 1'b0; say__RDY = 1'b1; echo__ENA = 1'b0; echo_v = 32'h0;
        active = 1'b0; corrupt_en = 1'b0; echo_budget = -1; check_steady = 1'b0;
        reset_model();
        #3;
        checks++;
        if ({say__ENA, echo__RDY, done, start__RDY} !== 4'b0001 || say_v !== 32'h0) begin
            errs++;
            $display("FAIL reset_outputs: got say %b echo_rdy %b done %b start_rdy %b say_v %h want 0 0 0 1 0",
                     say__ENA, echo__RDY, done, start__RDY, say_v);
        end
        checks++;
        if (sent !== 16'h0 || received !== 16'h0 || errors !== 16'h0) begin
            errs++;
            $display("FAIL reset_counters: got %0d %0d %0d want 0 0 0", sent, received, errors);
        end
        @(negedge CLK);
        @(negedge CLK);
        say__RDY = 1'b0;
        nRST = 1'b1;
    endtask

    task automatic test_loopback();
        bit sd;
        do_start();
        run_traffic(100, 50, 400, 1'b1, 0, sd);
        check_final("loopback", sd, 0);
    endtask

    task automatic test_stall();
        bit sd;
        do_start();
        echo_budget = 0;
        run_traffic(100, 100, 12, 1'b0, 0, sd);
        checks++;
        if (say_pulses !== MAX_OUT || sent !== 16'(MAX_OUT)) begin
            errs++;
            $display("FAIL stall_credit: got pulses %0d sent %0d want %0d", say_pulses, sent, MAX_OUT);
        end
        say_pulses  = 0;
        echo_budget = 1;
        run_traffic(100, 100, 6, 1'b0, 0, sd);
        checks++;
        if (say_pulses !== 1 || sent !== 16'(MAX_OUT + 1)) begin
            errs++;
            $display("FAIL stall_release: got pulses %0d sent %0d want 1 %0d", say_pulses, sent, MAX_OUT + 1);
        end
        echo_budget = -1;
        run_traffic(100, 70, 400, 1'b1, 0, sd);
        check_final("stall", sd, 0);
    endtask

    task automatic test_corrupt();
        bit sd;
        corrupt_en = 1'b1;
        do_start();
        run_traffic(70, 60, 600, 1'b1, 0, sd);
        check_final("corrupt", sd, 2);
        corrupt_en = 1'b0;
    endtask

    task automatic test_back_to_back();
        bit sd;
        check_steady = 1'b1;
        do_start();
        run_traffic(100, 100, 200, 1'b1, 0, sd);
        check_steady = 1'b0;
        check_final("back_to_back", sd, 0);
    endtask

    task automatic test_async_reset();
        bit sd;
        do_start();
        run_traffic(100, 50, 100, 1'b0, 5, sd);
        say__RDY = 1'b1;
        #2;
        nRST = 1'b0;
        #1;
        checks++;
        if ({say__ENA, echo__RDY, done, start__RDY} !== 4'b0001 || say_v !== 32'h0) begin
            errs++;
            $display("FAIL async_reset_outputs: got say %b echo_rdy %b done %b start_rdy %b say_v %h want 0 0 0 1 0",
                     say__ENA, echo__RDY, done, start__RDY, say_v);
        end
        checks++;
        if (sent !== 16'h0 || received !== 16'h0 || errors !== 16'h0) begin
            errs++;
            $display("FAIL async_reset_counters: got %0d %0d %0d want 0 0 0", sent, received, errors);
        end
        echo__ENA = 1'b1;
        echo_v    = BASE;
        @(negedge CLK);
        @(negedge CLK);
        echo__ENA = 1'b0;
        say__RDY  = 1'b0;
        nRST      = 1'b1;
        #1;
        checks++;
        if (received !== 16'h0 || say__ENA !== 1'b0) begin
            errs++;
            $display("FAIL async_reset_hold: got received %0d say %b want 0 0", received, say__ENA);
        end
        active = 1'b0;
        reset_model();
        do_start();
        run_traffic(100, 60, 400, 1'b1, 0, sd);
        check_final("restart", sd, 0);
    endtask

    task automatic test_spurious();
        bit sd;
        @(negedge CLK);
        nRST = 1'b0;
        @(negedge CLK);
        nRST = 1'b1;
        active = 1'b0;
        reset_model();
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            echo__ENA = 1'b1;
            echo_v    = 32'hDEAD;
        end
        @(negedge CLK);
        echo__ENA = 1'b0;
        #1;
        checks++;
        if (errors !== 16'h0 || received !== 16'h0 || start__RDY !== 1'b1) begin
            errs++;
            $display("FAIL spurious_idle: got errors %0d received %0d start_rdy %b want 0 0 1",
                     errors, received, start__RDY);
        end
        do_start();
        @(negedge CLK);
        start__ENA = 1'b0;
        say__RDY   = 1'b0;
        echo__ENA  = 1'b1;
        echo_v     = 32'hDEAD;
        #1;
        checks++;
        if (echo__RDY !== 1'b1) begin
            errs++;
            $display("FAIL spurious_run_rdy: got %b want 1", echo__RDY);
        end
        @(negedge CLK);
        echo__ENA = 1'b0;
        #1;
        checks++;
        if (errors !== 16'd1 || received !== 16'h0 || sent !== 16'h0) begin
            errs++;
            $display("FAIL spurious_run: got errors %0d received %0d sent %0d want 1 0 0",
                     errors, received, sent);
        end
        exp_err = 1;
        run_traffic(100, 50, 400, 1'b1, 0, sd);
        check_final("spurious", sd, 1);
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_stall();
        test_corrupt();
        test_back_to_back();
        test_async_reset();
        test_spurious();
        $display("CHECKS %0d ERRORS %0d", checks, errs);
        $finish;
    end

endmodule

// File: doc/l_class_oc_echodriver.md
# l_class_OC_EchoDriver

Traffic generator and checker for the far end of the echo request/indication interface. It issues a programmed sequence of `say` requests into an echo server. It acts as the `EchoIndication` responder, accepting each returned `echo` and checking it against the expected in-order value. A bounded credit counter limits the number of requests in flight. The block sits in the test/top level, wired `say*` to the server's request port and `echo*` to the server's `ind$echo*` port.

## Interface
Parameters:
- COUNT, 16: number of `say` requests per run (1..65535).
- BASE, 32'h100: value of the first request; request i carries BASE+i.
- MAX_OUT, 4: maximum outstanding requests (1..15).

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- start__ENA  in  1  begin a run; honoured only when start__RDY.
- start__RDY  out  1  high in IDLE and DONE.
- say__ENA  out  1  issue request this cycle.
- say_v  out  32  request payload.
- say__RDY  in  1  server can accept a request.
- echo__ENA  in  1  server delivers an indication this cycle.
- echo_v  in  32  indication payload.
- echo__RDY  out  1  driver can accept an indication.
- done  out  1  run complete; all echoes received.
- errors  out  16  mismatch count, saturating at 16'hFFFF.
- sent  out  16  requests issued this run.
- received  out  16  indications accepted this run.

## Operation
- Registers: state (IDLE, RUN, DRAIN, DONE), sent[15:0], received[15:0], outstanding[3:0], errors[15:0].
- IDLE: start__RDY=1, echo__RDY=0, say__ENA=0. On start__ENA, clear sent, received, outstanding and errors, then go to RUN.
- RUN:
  - say__ENA = say__RDY & (sent<COUNT) & (outstanding<MAX_OUT). This is combinational from say__RDY; the handshake completes in the same cycle.
  - say_v = BASE + sent (32-bit add, wraps mod 2^32); it is 0 whenever say__ENA=0.
  - Each issued request increments sent and outstanding.
  - echo__RDY=1.
  - Go to DRAIN at the edge on which sent reaches COUNT.
- Echo acceptance, in RUN or DRAIN:
  - On echo__ENA & echo__RDY, compare echo_v with BASE + received.
  - On mismatch, increment errors (saturating).
  - Always increment received and decrement outstanding.
- Simultaneous say and echo in the same cycle: outstanding is unchanged; sent and received both increment.
- DRAIN: say__ENA=0 and echo__RDY=1. Go to DONE when received reaches COUNT.
- DONE:
  - done=1 and start__RDY=1; counters hold their values.
  - start__ENA clears the counters and enters RUN directly.
- Indication protocol violations:
  - echo__ENA while echo__RDY=0 is ignored: no counter change, no error.
  - echo__ENA in RUN with outstanding==0 is treated as an error. errors increments; received and outstanding are unchanged, so outstanding never underflows.

## Timing
- Reset (nRST low, asynchronous): state=IDLE; sent, received, outstanding and errors are 0.
- Outputs during reset: done=0, say__ENA=0, say_v=0, echo__RDY=0, start__RDY=1.
- Reset mid-run aborts immediately with no further say__ENA. Echoes arriving after reset are not accepted.
- Request latency: the first say__ENA can assert the cycle after the start__ENA edge. One request per cycle maximum.
- Indication acceptance: echo__RDY is registered from state only, with no combinational path from echo__ENA. One echo per cycle maximum.
- Credit limit: at outstanding==MAX_OUT, say__ENA stays 0 that cycle even if an echo arrives. The freed credit is usable the next cycle.
- done asserts the cycle after the edge that accepts the COUNT-th echo.
- Counters are 16-bit and, with COUNT<=65535, never wrap; errors saturates.

## Test plan
- Loopback with the echo server, COUNT=16, BASE=32'h100, say__RDY held 1: say_v runs 0x100..0x10F with no gaps while credit is available. done=1, errors=0, sent=received=16.
- Server stalled (say__RDY=1, echo never delivered), MAX_OUT=4: exactly 4 say__ENA pulses, then say__ENA stays 0. Releasing one echo allows exactly one more request on the following cycle.
- Corrupted echo: bench flips echo_v bit 0 on indications 3 and 7. Final errors=2, received=16, done=1.
- Simultaneous say__ENA and echo__ENA every cycle in steady state: outstanding constant. Final sent=received=COUNT, and done follows the last echo by 1 cycle.
- nRST pulsed low mid-run after 5 requests:
  - outputs return to reset values asynchronously, without waiting for CLK;
  - a new start__ENA restarts say_v at BASE, and the run completes with errors=0.
- Spurious echo__ENA with echo_v=0xDEAD in IDLE is ignored (errors=0). The same echo in RUN with outstanding==0 gives errors=1 and received unchanged.
